// File: rtl/pc_pkg.sv
// Shared constants and state type for the PIC16-style program-counter sequencer.
package pc_pkg;
   localparam int PC_W = 11;
   localparam logic [PC_W-1:0] RESET_VEC = 11'h000;
   localparam logic [PC_W-1:0] INT_VEC   = 11'h004;
   localparam int STK_DEPTH = 16;
   localparam int DEPTH_W   = $clog2(STK_DEPTH + 1);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } seq_state_t;
endpackage

// File: rtl/pc_sequencer_stk_depth_guard.sv
// Return-stack depth tracker with sticky overflow/underflow flags.
// Only instantiated when STACK_GUARD_EN is defined.
module stk_depth_guard
   import pc_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic push,
   input  logic pop,
   input  logic stk_clr,
   output logic stkovf,
   output logic stkunf
);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STK_DEPTH);

   logic [DEPTH_W-1:0] depth_reg, depth_next;
   logic               ovf_reg, unf_reg;
   logic               ovf_set, unf_set;

   assign ovf_set = push && (depth_reg == DEPTH_MAX);
   assign unf_set = pop && (depth_reg == '0);

   // Depth saturates at both ends; the stack itself still wraps.
   always_comb begin
      depth_next = depth_reg;
      if (push && !ovf_set)
         depth_next = depth_reg + 1'b1;
      else if (pop && !unf_set)
         depth_next = depth_reg - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         depth_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else if (en) begin
         depth_reg <= depth_next;
         ovf_reg   <= ovf_set | (ovf_reg & ~stk_clr);
         unf_reg   <= unf_set | (unf_reg & ~stk_clr);
      end
   end

   assign stkovf = ovf_reg;
   assign stkunf = unf_reg;
endmodule

// File: rtl/pc_sequencer.sv
// Program counter / control-flow sequencer with two-stage pipeline flush.
// Optional stack depth guard enabled by defining STACK_GUARD_EN.
module pc_sequencer
   import pc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            op_call,
   input  logic            op_goto,
   input  logic            op_ret,
   input  logic            op_skip,
   input  logic [PC_W-1:0] k,
   input  logic            irq,
   input  logic [PC_W-1:0] stack_out,
   input  logic            stk_clr,
   output logic [PC_W-1:0] pc_out,
   output logic            flush,
   output logic            irq_ack,
   output logic            stack_push,
   output logic            stack_pop,
   output logic [PC_W-1:0] stack_in,
   output logic            stkovf,
   output logic            stkunf
);
   seq_state_t      state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic [PC_W-1:0] pc_inc;

   assign pc_inc = pc_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      irq_ack    = 1'b0;
      if (en) begin
         case (state_reg)
            RUN: begin
               state_next = FLUSH;
               if (irq) begin
                  stack_push = 1'b1;
                  irq_ack    = 1'b1;
                  pc_next    = INT_VEC;
               end else if (op_ret) begin
                  stack_pop = 1'b1;
                  pc_next   = stack_out;
               end else if (op_call) begin
                  stack_push = 1'b1;
                  pc_next    = k;
               end else if (op_goto) begin
                  pc_next = k;
               end else if (op_skip) begin
                  pc_next = pc_inc;
               end else begin
                  pc_next    = pc_inc;
                  state_next = RUN;
               end
            end
            // The bubble fetched behind a transfer is never executed.
            FLUSH: begin
               pc_next    = pc_inc;
               state_next = RUN;
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= RUN;
         pc_reg    <= RESET_VEC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   assign pc_out   = pc_reg;
   assign stack_in = pc_reg;
   assign flush    = (state_reg == FLUSH);

`ifdef STACK_GUARD_EN
   stk_depth_guard u_guard (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .push    (stack_push),
      .pop     (stack_pop),
      .stk_clr (stk_clr),
      .stkovf  (stkovf),
      .stkunf  (stkunf)
   );
`else
   logic unused_stk_clr;
   assign unused_stk_clr = stk_clr;
   assign stkovf = 1'b0;
   assign stkunf = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle model queues expected outputs per cycle.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        op_call = 1'b0, op_goto = 1'b0, op_ret = 1'b0, op_skip = 1'b0;
   logic [10:0] k = '0;
   logic        irq = 1'b0;
   logic [10:0] stack_out = '0;
   logic        stk_clr = 1'b0;
   logic [10:0] pc_out, stack_in;
   logic        flush, irq_ack, stack_push, stack_pop, stkovf, stkunf;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [10:0] pc;
      logic        fl, push, pop, ack, ovf, unf;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state
   logic [10:0] m_pc;
   logic        m_st;
   int          m_depth;
   logic        m_ovf, m_unf;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .en(en),
      .op_call(op_call), .op_goto(op_goto), .op_ret(op_ret), .op_skip(op_skip),
      .k(k), .irq(irq), .stack_out(stack_out), .stk_clr(stk_clr),
      .pc_out(pc_out), .flush(flush), .irq_ack(irq_ack),
      .stack_push(stack_push), .stack_pop(stack_pop), .stack_in(stack_in),
      .stkovf(stkovf), .stkunf(stkunf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_pc = 11'h000; m_st = 1'b0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
      exp_q.delete();
   endtask

   task automatic clear_ops();
      op_call = 0; op_goto = 0; op_ret = 0; op_skip = 0; irq = 0; stk_clr = 0; en = 1;
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic tick();
      exp_t e, g;
      logic [10:0] n_pc;
      logic        n_st;
      #1;
      e.pc = m_pc; e.fl = m_st; e.push = 0; e.pop = 0; e.ack = 0;
      e.ovf = m_ovf; e.unf = m_unf;
      if (en && !m_st) begin
         if (irq) begin e.push = 1; e.ack = 1; end
         else if (op_ret) e.pop = 1;
         else if (op_call) e.push = 1;
      end
      exp_q.push_back(e);
      n_pc = m_pc; n_st = m_st;
      if (en) begin
         if (m_st) begin n_pc = m_pc + 11'd1; n_st = 0; end
         else if (irq) begin n_pc = 11'h004; n_st = 1; end
         else if (op_ret) begin n_pc = stack_out; n_st = 1; end
         else if (op_call || op_goto) begin n_pc = k; n_st = 1; end
         else if (op_skip) begin n_pc = m_pc + 11'd1; n_st = 1; end
         else n_pc = m_pc + 11'd1;
      end
      #1;
      g = exp_q.pop_front();
      $display("pc=%h fl=%b push=%b pop=%b ack=%b ovf=%b unf=%b", pc_out, flush,
               stack_push, stack_pop, irq_ack, stkovf, stkunf);
      chk("pc_out", pc_out, g.pc);
      chk("stack_in", stack_in, g.pc);
      chk("flush", flush, g.fl);
      chk("push", stack_push, g.push);
      chk("pop", stack_pop, g.pop);
      chk("irq_ack", irq_ack, g.ack);
      chk("stkovf", stkovf, g.ovf);
      chk("stkunf", stkunf, g.unf);
      @(posedge clk);
      m_pc = n_pc; m_st = n_st;
`ifdef STACK_GUARD_EN
      if (en) begin
         m_ovf = m_ovf & ~stk_clr;
         m_unf = m_unf & ~stk_clr;
         if (e.push) begin
            if (m_depth == 16) m_ovf = 1; else m_depth++;
         end else if (e.pop) begin
            if (m_depth == 0) m_unf = 1; else m_depth--;
         end
      end
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 0;
      @(negedge clk);
      reset = 1;
      model_reset();
   endtask

   initial begin
      clear_ops();
      en = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_pc", pc_out, 11'h000);
      chk("rst_flush", flush, 1'b0);
      chk("rst_ack", irq_ack, 1'b0);
      chk("rst_ovf", stkovf, 1'b0);
      chk("rst_unf", stkunf, 1'b0);
      reset = 1;
      en = 1;

      // Sequential fetch from reset vector
      repeat (5) tick();
      chk("seq_pc5", pc_out, 11'h005);

      // Reach 0x010 then CALL 0x123
      op_goto = 1; k = 11'h00F; tick(); clear_ops(); tick();
      op_call = 1; k = 11'h123; tick(); clear_ops();
      chk("call_tgt", pc_out, 11'h123);
      chk("call_flush", flush, 1'b1);
      tick();
      chk("call_next", pc_out, 11'h124);

      // RETURN, with a CALL during the bubble that must be ignored
      op_ret = 1; stack_out = 11'h010; tick(); clear_ops();
      chk("ret_tgt", pc_out, 11'h010);
      op_call = 1; k = 11'h3AA; tick(); clear_ops();
      tick();

      // IRQ beats GOTO; IRQ held through FLUSH is honoured afterwards
      op_goto = 1; k = 11'h04F; tick(); clear_ops(); tick();
      irq = 1; op_goto = 1; k = 11'h200; tick(); op_goto = 0;
      chk("irq_vec", pc_out, 11'h004);
      tick();
      tick();
      irq = 0; tick(); tick();

      // en low holds everything
      en = 0; op_call = 1; k = 11'h555; tick(); tick(); clear_ops();
      tick();

      // Wrap and skip
      op_goto = 1; k = 11'h7FE; tick(); clear_ops(); tick();
      tick();
      chk("wrap", pc_out, 11'h000);
      op_goto = 1; k = 11'h01F; tick(); clear_ops(); tick();
      op_skip = 1; tick(); clear_ops();
      chk("skip_pc", pc_out, 11'h021);
      chk("skip_fl", flush, 1'b1);
      tick(); tick();

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         en = ($urandom_range(0, 3) != 0);
         irq = ($urandom_range(0, 7) == 0);
         op_ret = ($urandom_range(0, 5) == 0);
         op_call = ($urandom_range(0, 4) == 0);
         op_goto = ($urandom_range(0, 5) == 0);
         op_skip = ($urandom_range(0, 5) == 0);
         stk_clr = ($urandom_range(0, 7) == 0);
         k = 11'($urandom);
         stack_out = 11'($urandom);
         tick();
      end
      clear_ops();

      // Stack guard: overflow on 17th call, then clear
      do_reset();
      for (int i = 0; i < 17; i++) begin
         op_call = 1; k = 11'(11'h100 + i); tick(); clear_ops(); tick();
      end
`ifdef STACK_GUARD_EN
      chk("ovf17", stkovf, 1'b1);
`else
      chk("ovf_off", stkovf, 1'b0);
`endif
      stk_clr = 1; tick(); clear_ops();
      chk("ovf_clr", stkovf, 1'b0);

      // Underflow on pop from empty
      do_reset();
      op_ret = 1; stack_out = 11'h0AB; tick(); clear_ops();
      chk("unf_pc", pc_out, 11'h0AB);
`ifdef STACK_GUARD_EN
      chk("unf_set", stkunf, 1'b1);
`else
      chk("unf_off", stkunf, 1'b0);
`endif
      tick();

      // Async reset in the middle of a FLUSH cycle
      op_call = 1; k = 11'h2C0; tick(); clear_ops();
      #3 reset = 0;
      #1;
      chk("arst_pc", pc_out, 11'h000);
      chk("arst_flush", flush, 1'b0);
      chk("arst_ovf", stkovf, 1'b0);
      chk("arst_unf", stkunf, 1'b0);
      @(negedge clk);
      reset = 1;
      model_reset();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
